mult_share_arb: RTL and testbench
=================================

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters; only the value 4 is supported.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port en, input, 1 bit: when high, new grants are allowed.
REQ-005 Port req, input, 4 bits: per-requester request, level-sensitive.
REQ-006 Port a_in, input, 16 bits: requester i multiplicand on bits [4i+3:4i].
REQ-007 Port b_in, input, 16 bits: requester i multiplier on bits [4i+3:4i].
REQ-008 Port ack, output, 4 bits: one-hot, one-cycle pulse marking completion for requester i.
REQ-009 Port y, output, 8 bits: registered unsigned product.
REQ-010 Port y_id, output, 2 bits: index of the requester owning y.
REQ-011 Port y_valid, output, 1 bit: one-cycle pulse; y and y_id are valid while it is high.

Function
REQ-012 The block SHALL time-share one 4x4 unsigned multiplier among 4 requesters using an FSM with states IDLE and CALC.
REQ-013 IDLE SHALL grant when en=1 and at least one eligible req bit is set; otherwise it SHALL stay in IDLE.
REQ-014 Eligible SHALL mean req[i]=1 and ack[i]=0 in the same cycle, so a requester still holding req during its ack cycle is not re-granted.
REQ-015 Arbitration SHALL be round-robin: search from index ptr upward modulo 4; the first eligible index wins.
REQ-016 On the grant edge the block SHALL latch the winner's 4-bit a and b slices into operand registers, latch the winner index, and move to CALC.
REQ-017 On the CALC edge the block SHALL register the product of the latched operands into y and set y_id to the winner index.
REQ-018 On the same CALC edge the block SHALL set y_valid=1 and ack[winner]=1 for exactly one cycle, set ptr to (winner+1) mod 4, and return to IDLE.
REQ-019 Latency SHALL be 2 cycles from the grant edge to the y_valid cycle; throughput SHALL be at most one product per 2 cycles.
REQ-020 Operands SHALL be sampled only at the grant edge; later changes to a_in, b_in or req SHALL NOT affect an in-flight product.
REQ-021 If req[winner] drops while in CALC, the operation SHALL still complete and ack SHALL still pulse.
REQ-022 If en goes low while in CALC, the in-flight operation SHALL complete; no new grant SHALL occur while en=0.
REQ-023 y and y_id SHALL hold their last values when y_valid=0.
REQ-024 The product SHALL be the full 8-bit value; the maximum is 15*15=225, so no overflow occurs.

Reset
REQ-025 While rst_n=0, the block SHALL reset asynchronously to: state=IDLE, ptr=0, operand registers=0, y=0, y_id=0, y_valid=0, ack=0.
REQ-026 A reset asserted in CALC SHALL abort the operation with no ack and no y_valid.
REQ-027 Arbitration SHALL resume one cycle after rst_n rises.

Structure
REQ-028 The block SHALL instantiate the existing mult4x4 combinational multiplier exactly once as its only sub-module.
REQ-029 State encodings (IDLE, CALC) and NUM_REQ SHALL be shared constants in a common package so the tone-generator mixer can reuse them.
REQ-030 The round-robin priority search SHALL be combinational logic inside this module.

Verification
REQ-031 Single request: after reset, req=0001 with a=7 and b=9. Required: grant on edge 1; on edge 2, y=63, y_id=0, y_valid=1 and ack=0001, each for one cycle.
REQ-032 All four requesting continuously (drop on ack, re-raise next cycle), ptr=0. Required: grant order 0,1,2,3,0, with a y_valid every 2 cycles.
REQ-033 Boundary operands: a=15, b=15 gives y=225; a=0, b=15 gives y=0; a=15, b=0 gives y=0.
REQ-034 Operand change after grant: a changed from 3 to 12 one cycle after grant with b=5. Required: y=15.
REQ-035 en dropped during CALC with req=1111. Required: the current result completes; no further grant until en returns high.
REQ-036 rst_n pulsed low during CALC. Required: no ack or y_valid; all outputs are 0; ptr restarts at 0.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// Purpose: constants and types for the shared-multiplier arbiter and the blocks that reuse its encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_share_arb_pkg;

  localparam int NUM_REQ = 4;  // requesters sharing one multiplier
  localparam int OP_W    = 4;  // operand width per requester
  localparam int PROD_W  = 8;  // full unsigned product width
  localparam int IDX_W   = 2;  // requester index width

  // Shared FSM encoding, also used by the tone-generator mixer.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/mult4x4.sv
// Purpose: combinational 4x4 unsigned multiplier producing the full 8-bit product.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a_i, b_i - 4-bit unsigned operands; p_o - 8-bit product.
module mult4x4
  import mult_share_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  // Zero-extend both operands so the product is never truncated.
  assign p_o = {4'b0000, a_i} * {4'b0000, b_i};

endmodule

// File: rtl/mult_share_arb.sv
// Purpose: time-shares one 4x4 multiplier among four requesters using round-robin arbitration.
// Latency: 2 cycles from the grant edge to y_valid; at most one product every 2 cycles.
// Backpressure: requesters hold req until their ack pulse; en=0 blocks new grants, in-flight work completes.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - allow new grants
//   req[3:0]        - level-sensitive per-requester request
//   a_in/b_in[15:0] - requester i operands on bits [4i+3:4i]
//   ack[3:0]        - one-hot, one-cycle completion pulse
//   y, y_id         - registered product and owning requester; held between results
//   y_valid         - one-cycle pulse marking a fresh y/y_id
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int NUM_REQ_P = NUM_REQ
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ_P-1:0]      req,
  input  logic [OP_W*NUM_REQ_P-1:0] a_in,
  input  logic [OP_W*NUM_REQ_P-1:0] b_in,
  output logic [NUM_REQ_P-1:0]      ack,
  output logic [PROD_W-1:0]         y,
  output logic [IDX_W-1:0]          y_id,
  output logic                      y_valid
);

  state_t                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       win_q;
  logic [OP_W-1:0]        op_a_q;
  logic [OP_W-1:0]        op_b_q;
  logic [PROD_W-1:0]      y_q;
  logic [IDX_W-1:0]       y_id_q;
  logic                   y_valid_q;
  logic [NUM_REQ_P-1:0]   ack_q;

  logic [NUM_REQ_P-1:0]   elig;
  logic                   grant_vld_d;
  logic [IDX_W-1:0]       grant_idx_d;
  logic [PROD_W-1:0]      prod;

  // A requester still holding req during its own ack cycle must not be re-granted.
  assign elig = req & ~ack_q;

  // Round-robin search starting at ptr_q. Iterating from the farthest offset
  // down lets the nearest eligible index overwrite earlier candidates.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_vld_d = 1'b0;
    grant_idx_d = ptr_q;
    idx         = ptr_q;
    for (int k = NUM_REQ_P - 1; k >= 0; k--) begin
      idx = ptr_q + IDX_W'(k);
      if (elig[idx]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = idx;
      end
    end
  end

  mult4x4 u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      y_q       <= '0;
      y_id_q    <= '0;
      y_valid_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      // Completion strobes are single-cycle pulses.
      y_valid_q <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        IDLE: begin
          if (en && grant_vld_d) begin
            // Operands are captured only here; later input changes cannot
            // disturb the product being computed.
            op_a_q  <= a_in[{grant_idx_d, 2'b00} +: OP_W];
            op_b_q  <= b_in[{grant_idx_d, 2'b00} +: OP_W];
            win_q   <= grant_idx_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          // Completes regardless of req or en so an accepted operation is never lost.
          y_q       <= prod;
          y_id_q    <= win_q;
          y_valid_q <= 1'b1;
          ack_q     <= NUM_REQ_P'(1) << win_q;
          ptr_q     <= win_q + IDX_W'(1);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign y       = y_q;
  assign y_id    = y_id_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  ack;
  logic [7:0]  y;
  logic [1:0]  y_id;
  logic        y_valid;

  int assertions = 0;
  int failures   = 0;

  mult_share_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .ack     (ack),
    .y       (y),
    .y_id    (y_id),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    en    = 1'b0;
    a_in  = 16'h0;
    b_in  = 16'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Raise a lone request for requester id and run it through grant and result edges.
  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b);
    req = 4'b0000;
    req[id] = 1'b1;
    a_in[4*id +: 4] = a;
    b_in[4*id +: 4] = b;
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; req = 4'b0; a_in = 16'h0; b_in = 16'h0;
    #2;
    assertions++;
    if ({ack, y, y_id, y_valid} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b y=%0d y_id=%0d y_valid=%b, required all 0", ack, y, y_id, y_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001; a_in = 16'h0007; b_in = 16'h0009; en = 1'b1;
    tick();
    assertions++;
    if (y_valid !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_grant_edge: y_valid=%b ack=%b, required 0 and 0000", y_valid, ack);
    end
    tick();
    assertions++;
    if (y !== 8'd63 || y_id !== 2'd0 || y_valid !== 1'b1 || ack !== 4'b0001) begin
      failures++;
      $display("FAIL single_result: y=%0d y_id=%0d y_valid=%b ack=%b, required 63 0 1 0001", y, y_id, y_valid, ack);
    end
    req = 4'b0000;
    tick();
    assertions++;
    if (y_valid !== 1'b0 || ack !== 4'b0000 || y !== 8'd63 || y_id !== 2'd0) begin
      failures++;
      $display("FAIL single_hold: y_valid=%b ack=%b y=%0d y_id=%0d, required 0 0000 63 0", y_valid, ack, y, y_id);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    logic [7:0] exp_y  [4];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    // a_i = i+1, b_i = i+2
    exp_y[0] = 8'd2; exp_y[1] = 8'd6; exp_y[2] = 8'd12; exp_y[3] = 8'd20;
    do_reset();
    a_in = 16'h4321; b_in = 16'h5432; en = 1'b1; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      req = 4'b1111;
      assertions++;
      if (y_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_grant_cycle%0d: y_valid=%b, required 0", n, y_valid);
      end
      tick();
      assertions++;
      if (y_valid !== 1'b1 || y_id !== exp_id[n] || y !== exp_y[exp_id[n]] ||
          ack !== (4'b0001 << exp_id[n])) begin
        failures++;
        $display("FAIL rr_result%0d: y_valid=%b y_id=%0d y=%0d ack=%b, required 1 %0d %0d %b",
                 n, y_valid, y_id, y, ack, exp_id[n], exp_y[exp_id[n]], 4'b0001 << exp_id[n]);
      end
      req = 4'b1111 & ~ack;  // drop on ack, re-raise next cycle
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_boundary();
    run_one(0, 4'd15, 4'd15);
    assertions++;
    if (y !== 8'd225 || y_valid !== 1'b1 || y_id !== 2'd0) begin
      failures++;
      $display("FAIL bound_15x15: y=%0d y_valid=%b y_id=%0d, required 225 1 0", y, y_valid, y_id);
    end
    req = 4'b0; tick();
    run_one(2, 4'd0, 4'd15);
    assertions++;
    if (y !== 8'd0 || y_valid !== 1'b1 || y_id !== 2'd2 || ack !== 4'b0100) begin
      failures++;
      $display("FAIL bound_0x15: y=%0d y_valid=%b y_id=%0d ack=%b, required 0 1 2 0100", y, y_valid, y_id, ack);
    end
    req = 4'b0; tick();
    run_one(3, 4'd15, 4'd0);
    assertions++;
    if (y !== 8'd0 || y_valid !== 1'b1 || y_id !== 2'd3 || ack !== 4'b1000) begin
      failures++;
      $display("FAIL bound_15x0: y=%0d y_valid=%b y_id=%0d ack=%b, required 0 1 3 1000", y, y_valid, y_id, ack);
    end
    req = 4'b0; tick();
  endtask

  task automatic test_operand_change();
    req = 4'b0010; a_in = 16'h0030; b_in = 16'h0050; en = 1'b1;
    tick();
    a_in = 16'h00C0;
    req  = 4'b0000;  // dropping req in CALC must not cancel the operation
    tick();
    assertions++;
    if (y !== 8'd15 || y_valid !== 1'b1 || y_id !== 2'd1 || ack !== 4'b0010) begin
      failures++;
      $display("FAIL operand_change: y=%0d y_valid=%b y_id=%0d ack=%b, required 15 1 1 0010", y, y_valid, y_id, ack);
    end
    tick();
  endtask

  task automatic test_en_drop();
    int stray;
    do_reset();
    a_in = 16'h4321; b_in = 16'h5432; req = 4'b1111; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    assertions++;
    if (y_valid !== 1'b1 || y_id !== 2'd0 || y !== 8'd2) begin
      failures++;
      $display("FAIL en_drop_complete: y_valid=%b y_id=%0d y=%0d, required 1 0 2", y_valid, y_id, y);
    end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (y_valid !== 1'b0 || ack !== 4'b0000) stray++;
    end
    assertions++;
    if (stray != 0) begin
      failures++;
      $display("FAIL en_low_no_grant: stray result cycles=%0d, required 0", stray);
    end
    en = 1'b1;
    tick();
    tick();
    assertions++;
    if (y_valid !== 1'b1 || y_id !== 2'd1 || y !== 8'd6) begin
      failures++;
      $display("FAIL en_resume: y_valid=%b y_id=%0d y=%0d, required 1 1 6", y_valid, y_id, y);
    end
    req = 4'b0; tick();
  endtask

  task automatic test_reset_in_calc();
    do_reset();
    a_in = 16'h4321; b_in = 16'h5432;
    run_one(0, 4'd1, 4'd2);  // leaves ptr at 1
    req = 4'b1111;
    tick();                  // requester 1 granted, now in CALC
    rst_n = 1'b0;
    #1;
    assertions++;
    if ({ack, y, y_id, y_valid} !== 15'h0) begin
      failures++;
      $display("FAIL calc_reset_outputs: ack=%b y=%0d y_id=%0d y_valid=%b, required all 0", ack, y, y_id, y_valid);
    end
    tick();
    assertions++;
    if (ack !== 4'b0000 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL calc_reset_abort: ack=%b y_valid=%b, required 0000 0", ack, y_valid);
    end
    rst_n = 1'b1;
    tick();
    tick();
    assertions++;
    if (y_valid !== 1'b1 || y_id !== 2'd0 || y !== 8'd2 || ack !== 4'b0001) begin
      failures++;
      $display("FAIL calc_reset_ptr: y_valid=%b y_id=%0d y=%0d ack=%b, required 1 0 2 0001", y_valid, y_id, y, ack);
    end
    req = 4'b0; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_operand_change();
    test_en_drop();
    test_reset_in_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
